// File: rtl/rv32_pkg.sv
// Shared RV32I constants: instruction type codes (common with instruction_decoder),
// major opcodes and a sign-extension range helper.
package rv32_pkg;

    typedef enum logic [2:0] {
        TYPE_UNK = 3'd0,
        TYPE_R   = 3'd1,
        TYPE_I   = 3'd2,
        TYPE_S   = 3'd3,
        TYPE_B   = 3'd4,
        TYPE_U   = 3'd5,
        TYPE_J   = 3'd6,
        TYPE_SYS = 3'd7
    } rv_type_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int ENC_W = 33;

    // True when v is the sign-extension of its low nbits bits.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned nbits);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << (nbits - 1);
        return ((v & m) == m) || ((v & m) == 32'h0);
    endfunction

endpackage

// File: rtl/rv_skid_buffer.sv
// Two-entry valid/ready buffer with registered outputs; ready is derived only
// from occupancy so it never depends combinationally on the downstream ready.
module rv_skid_buffer #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_cnt;

    logic w_push;
    logic w_pop;

    assign o_ready = (r_cnt != 2'd2);
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_head;

    assign w_push = i_valid && o_ready;
    assign w_pop  = o_valid && i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_head <= i_data;
                    end else begin
                        r_tail <= i_data;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // Occupancy holds; the new word lands behind whatever remains.
                    if (r_cnt == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/rv32_instr_encoder.sv
// RV32I field-bundle to instruction-word encoder with legality check and a
// 2-entry output buffer. Optional statistics counters under RV_ENC_STATS_EN.
module rv32_instr_encoder
    import rv32_pkg::*;
#(
    parameter logic [31:0] ILLEGAL_WORD  = 32'h0000_0000,
    parameter int          STRICT_OPCODE = 1
`ifdef RV_ENC_STATS_EN
   ,parameter int          CNT_W         = 16
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_type,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err
`ifdef RV_ENC_STATS_EN
   ,output logic [CNT_W-1:0] cnt_ok
   ,output logic [CNT_W-1:0] cnt_err
`endif
);

    // Returns {err, word}; the word is replaced by ILLEGAL_WORD on any failure.
    function automatic logic [ENC_W-1:0] encode(
        input logic [2:0]  t,
        input logic [6:0]  opc,
        input logic [4:0]  rd,
        input logic [2:0]  f3,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] w;
        logic        legal;
        logic        opc_ok;
        w      = 32'h0;
        legal  = 1'b0;
        opc_ok = 1'b0;
        case (t)
            TYPE_R: begin
                w      = {f7, rs2, rs1, f3, rd, opc};
                legal  = 1'b1;
                opc_ok = (opc == OPC_OP);
            end
            TYPE_I: begin
                w      = {imm[11:0], rs1, f3, rd, opc};
                legal  = fits_signed(imm, 12);
                opc_ok = opc inside {OPC_OPIMM, OPC_LOAD, OPC_JALR};
            end
            TYPE_S: begin
                w      = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
                legal  = fits_signed(imm, 12);
                opc_ok = (opc == OPC_STORE);
            end
            TYPE_B: begin
                w      = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
                legal  = fits_signed(imm, 13) && !imm[0];
                opc_ok = (opc == OPC_BRANCH);
            end
            TYPE_U: begin
                w      = {imm[31:12], rd, opc};
                legal  = (imm[11:0] == 12'h000);
                opc_ok = opc inside {OPC_LUI, OPC_AUIPC};
            end
            TYPE_J: begin
                w      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
                legal  = fits_signed(imm, 21) && !imm[0];
                opc_ok = (opc == OPC_JAL);
            end
            TYPE_SYS: begin
                w      = {imm[11:0], rs1, f3, rd, opc};
                legal  = fits_signed(imm, 12);
                opc_ok = (opc == OPC_SYSTEM);
            end
            default: begin
                w      = 32'h0;
                legal  = 1'b0;
                opc_ok = 1'b0;
            end
        endcase
        if (STRICT_OPCODE == 0) begin
            opc_ok = 1'b1;
        end
        if (legal && opc_ok) begin
            return {1'b0, w};
        end
        return {1'b1, ILLEGAL_WORD};
    endfunction

    logic [ENC_W-1:0] w_enc;
    logic [ENC_W-1:0] w_out_data;

    assign w_enc = encode(in_type, in_opcode, in_rd, in_funct3,
                          in_rs1, in_rs2, in_funct7, in_imm);

    rv_skid_buffer #(
        .W (ENC_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_enc),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_out_data)
    );

    assign out_err   = w_out_data[ENC_W-1];
    assign out_instr = w_out_data[31:0];

`ifdef RV_ENC_STATS_EN
    logic [CNT_W-1:0] r_cnt_ok;
    logic [CNT_W-1:0] r_cnt_err;
    logic             w_deliver;

    assign w_deliver = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_ok  <= '0;
            r_cnt_err <= '0;
        end else if (w_deliver) begin
            if (!out_err && (r_cnt_ok != {CNT_W{1'b1}})) begin
                r_cnt_ok <= r_cnt_ok + CNT_W'(1);
            end
            if (out_err && (r_cnt_err != {CNT_W{1'b1}})) begin
                r_cnt_err <= r_cnt_err + CNT_W'(1);
            end
        end
    end

    assign cnt_ok  = r_cnt_ok;
    assign cnt_err = r_cnt_err;
`endif

endmodule
